// File: rtl/rk_tape_pkg.sv
// Shared types and constants for the RK cassette tape player.
// Holds the framing states, the default framing bytes and the half-bit level rule.
package rk_tape_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_SYNC,
        S_DATA,
        S_STALL,
        S_FINISH
    } state_t;

    localparam logic [7:0] LEADER_BYTE   = 8'h00;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hE6;

    // Phase encoding: first half is the inverted bit, second half the bit itself
    function automatic logic level(input logic b, input logic half);
        return half ? b : ~b;
    endfunction

endpackage

// File: rtl/rk_tape_bitgen.sv
// Half-bit timer, 16-half sequencer and shift register for one tape byte.
// Drives the tape level register; byte_done marks the end of the 16th half.
module rk_tape_bitgen
    import rk_tape_pkg::*;
#(
    parameter int HALF_BIT = 741
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       run,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] ld_byte,
    output logic       byte_done,
    output logic       tape_out
);

    localparam int TW = $clog2(HALF_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(HALF_BIT - 1);

    logic [TW-1:0] r_tmr;
    logic [3:0]    r_half;
    logic [7:0]    r_shift;
    logic          r_tape;
    logic          w_half_end;

    assign w_half_end = run & ce & (r_tmr == T_LAST);
    assign byte_done  = w_half_end & (r_half == 4'd15);
    assign tape_out   = r_tape;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tmr   <= '0;
            r_half  <= '0;
            r_shift <= '0;
            r_tape  <= 1'b0;
        end else if (clr) begin
            r_tmr   <= '0;
            r_half  <= '0;
            r_shift <= '0;
            r_tape  <= 1'b0;
        end else if (load) begin
            r_tmr   <= '0;
            r_half  <= '0;
            r_shift <= ld_byte;
            r_tape  <= level(ld_byte[7], 1'b0);
        end else if (byte_done) begin
            // No follow-on byte: level is frozen until the next load
            r_tmr  <= '0;
            r_half <= '0;
        end else if (w_half_end) begin
            r_tmr  <= '0;
            r_half <= r_half + 4'd1;
            if (!r_half[0]) begin
                r_tape <= level(r_shift[7], 1'b1);
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_tape  <= level(r_shift[6], 1'b0);
            end
        end else if (run && ce) begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

endmodule

// File: rtl/rk_tape_player.sv
// RK cassette transmitter: leader, sync byte, then phase-encoded payload.
// Framing FSM and one-entry holding register; bit timing lives in rk_tape_bitgen.
module rk_tape_player
    import rk_tape_pkg::*;
#(
    parameter int         HALF_BIT   = 741,
    parameter int         LEADER_LEN = 256,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tape_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int CW = (LEADER_LEN > 1) ? $clog2(LEADER_LEN) : 1;

    state_t        r_state;
    state_t        w_nx;
    logic [CW-1:0] r_cnt;
    logic          r_hold_full;
    logic [7:0]    r_hold_data;
    logic          r_hold_last;
    logic          r_last_acc;
    logic          r_last_sent;
    logic          r_underrun;

    logic       w_load;
    logic       w_clr;
    logic       w_pop;
    logic       w_direct;
    logic       w_stall;
    logic       w_dec;
    logic       w_go;
    logic       w_run;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_byte_done;
    logic [7:0] w_ld_byte;

    assign w_run = (r_state == S_LEADER) | (r_state == S_SYNC)
                 | (r_state == S_DATA);

    assign w_in_ready = ~abort & ~r_hold_full & ~r_last_acc
                      & ((r_state == S_SYNC) | (r_state == S_DATA)
                       | (r_state == S_STALL));

    assign w_accept = in_valid & w_in_ready;
    assign in_ready = w_in_ready;
    assign busy     = w_run | (r_state == S_STALL);
    assign done     = (r_state == S_FINISH);
    assign underrun = r_underrun;

    always_comb begin
        w_nx      = r_state;
        w_load    = 1'b0;
        w_ld_byte = LEADER_BYTE;
        w_clr     = 1'b0;
        w_pop     = 1'b0;
        w_direct  = 1'b0;
        w_stall   = 1'b0;
        w_dec     = 1'b0;
        w_go      = 1'b0;
        if (abort) begin
            w_nx  = S_IDLE;
            w_clr = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_go   = 1'b1;
                        w_load = 1'b1;
                        w_nx   = S_LEADER;
                    end
                end
                S_LEADER: begin
                    if (w_byte_done) begin
                        w_load = 1'b1;
                        if (r_cnt == '0) begin
                            w_ld_byte = SYNC_BYTE;
                            w_nx      = S_SYNC;
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                end
                S_SYNC, S_DATA: begin
                    if (w_byte_done) begin
                        if (r_hold_full) begin
                            w_pop     = 1'b1;
                            w_load    = 1'b1;
                            w_ld_byte = r_hold_data;
                            w_nx      = S_DATA;
                        end else if (w_accept) begin
                            w_direct  = 1'b1;
                            w_load    = 1'b1;
                            w_ld_byte = in_data;
                            w_nx      = S_DATA;
                        end else if (r_last_sent) begin
                            w_clr = 1'b1;
                            w_nx  = S_FINISH;
                        end else begin
                            w_stall = 1'b1;
                            w_nx    = S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (w_accept) begin
                        w_direct  = 1'b1;
                        w_load    = 1'b1;
                        w_ld_byte = in_data;
                        w_nx      = S_DATA;
                    end
                end
                S_FINISH: w_nx = S_IDLE;
                default:  w_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nx;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_last_acc  <= 1'b0;
            r_last_sent <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (abort) begin
            r_hold_full <= 1'b0;
            r_last_acc  <= 1'b0;
            r_last_sent <= 1'b0;
        end else begin
            if (w_go) begin
                r_underrun  <= 1'b0;
                r_cnt       <= CW'(LEADER_LEN - 1);
                r_hold_full <= 1'b0;
                r_last_acc  <= 1'b0;
                r_last_sent <= 1'b0;
            end
            if (w_dec) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_stall) begin
                r_underrun <= 1'b1;
            end
            if (w_pop) begin
                r_hold_full <= 1'b0;
                r_last_sent <= r_hold_last;
            end
            // Accepted bytes either bypass straight to the shifter or park here
            if (w_accept) begin
                r_last_acc <= in_last;
                if (w_direct) begin
                    r_last_sent <= in_last;
                end else begin
                    r_hold_full <= 1'b1;
                    r_hold_data <= in_data;
                    r_hold_last <= in_last;
                end
            end
        end
    end

    rk_tape_bitgen #(
        .HALF_BIT (HALF_BIT)
    ) u_bitgen (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .run       (w_run),
        .clr       (w_clr),
        .load      (w_load),
        .ld_byte   (w_ld_byte),
        .byte_done (w_byte_done),
        .tape_out  (tape_out)
    );

endmodule
